mux_21_rr_sel: RTL and testbench
================================

Name: mux_21_rr_sel

Overview:
- Round-robin select generator that sits directly upstream of the 2:1 dataflow mux.
- Arbitrates between two requesting sources and drives the mux select `s`.
- Holds each grant for up to BURST cycles, then passes ownership fairly to the other source.
- Also produces one-hot grants and beat framing (`busy`, `last`) for downstream consumers of the mux output.

Parameters:
- BURST, 4, maximum consecutive cycles one source may own the mux per grant. Legal range 1..256.
- CW, 8, width of the internal beat counter. Must satisfy 2^CW >= BURST.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  2  req[k]=1 means source k wants the mux. Level-sensitive.
- s  output  1  mux select. 0 selects i[0], 1 selects i[1]. Connects directly to the mux `s` input.
- gnt  output  2  one-hot grant. gnt[k]=1 means source k currently owns the mux. 00 means idle.
- busy  output  1  equals gnt[0]|gnt[1].
- last  output  1  high on the final granted beat of a burst, when that end is caused by reaching BURST.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous and active-high.
  - All state updates on the rising edge of clk.
  - While rst=1 at an edge, the next state is s=0, gnt=00, busy=0, last=0, cnt=0, ptr=1.
  - ptr=1 means source 0 has priority for the first arbitration.
- Registered state:
  - gnt[1:0], cnt[CW-1:0], ptr (index of the most recent winner), s.
- Outputs:
  - All outputs are registered, except busy and last, which are pure decodes of registered state.
- States:
  - IDLE (gnt=00) and OWN0 (gnt=01) and OWN1 (gnt=10).
- Release condition:
  - rel = busy & (cnt==BURST-1 | ~req[s]).
- Arbitration:
  - Happens whenever the state is IDLE or rel=1.
  - Only req=01 present: winner is 0. Only req=10 present: winner is 1.
  - req=11: winner is ~ptr.
  - req=00: next state is IDLE.
- On a win:
  - Next gnt is onehot(winner), s=winner, ptr=winner, cnt=0.
- Hold:
  - When busy and not rel: gnt, s and ptr hold, and cnt increments by 1.
- Latency:
  - A request seen in IDLE at edge t produces gnt at edge t+1, one cycle later.
  - No idle gap between back-to-back grants. At a release with pending requests, the next owner is granted on the following edge.
- Fairness:
  - When a burst ends at BURST and both sources request, ownership switches.
  - When only the current owner still requests, it is re-granted immediately with cnt reset to 0.
- Early drop:
  - If the owner's req falls while it is granted, that cycle is its final beat.
  - gnt updates on the next edge.
  - last is not asserted for an early drop.
  - last = busy & (cnt==BURST-1).
- Select behaviour:
  - s only changes on a new grant.
  - In IDLE, s holds the previous owner's index, so the mux output does not glitch between owners.
- BURST=1:
  - Every granted cycle is a release, and last is high on every busy cycle.
  - With req=11, ownership alternates 0,1,0,1 every cycle.
- Counter:
  - Never exceeds BURST-1 and never wraps. It is cleared on every grant.
- Reset mid-burst:
  - Aborts immediately. The next cycle is IDLE with ptr=1.
  - A burst in progress is not resumed after reset.
- Invariants:
  - gnt is never 11.
  - busy=1 implies gnt[s]=1.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req=11, then release → during reset gnt=00, s=0. One cycle after release gnt=01, s=0.
- Single source, BURST=4: req=10 held for 10 cycles → gnt=10 continuously from cycle 1. last is high on cycles 4 and 8, and cnt restarts at 0 after each last.
- Contention, BURST=4: req=11 constant → gnt sequence is 01×4, 10×4, 01×4. s toggles on each switch edge, last pulses every 4th cycle, with no idle cycles.
- Early drop: grant source 0, drop req[0] after 2 granted cycles while req[1]=1 → gnt=10 on the next edge. last stays 0 for the truncated burst.
- Idle and hold: req=01 for 2 cycles, then req=00 → gnt=00 and busy=0, while s stays 0. A later req=10 gives s=1 one cycle after.
- BURST=1 and reset mid-burst: req=11 gives gnt alternating 01/10 each cycle. Asserting rst during gnt=10 gives gnt=00 next cycle, then 01 after release.

Source files
------------

// File: rtl/mux_21_rr_sel.sv
// Round-robin select generator for a 2:1 dataflow mux.
// Grants one of two level-sensitive requesters for up to BURST beats, then
// hands ownership to the other source if it is waiting. Drives the mux
// select, a one-hot grant and beat framing (busy/last).
//
// state | meaning
// IDLE  | no owner, gnt=00, s holds previous owner's index
// OWN0  | source 0 owns the mux, gnt=01
// OWN1  | source 1 owns the mux, gnt=10
module mux_21_rr_sel #(
  parameter int BURST = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic       s,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       last
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ptr;
  logic            at_max;
  logic            rel;
  logic            arb;
  logic            win;

  assign gnt    = state;
  assign busy   = (state != IDLE);
  assign at_max = (cnt == CNT_MAX);
  assign last   = busy & at_max;

  // Release on the final beat of a full burst or when the owner drops its request.
  assign rel = busy & (at_max | ~req[s]);
  assign arb = ~busy | rel;

  // Contention goes to the source that did not win most recently.
  assign win = (req == 2'b11) ? ~ptr : req[1];

  // Ownership, beat counter and select update; s only moves on a new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b1;
      s     <= 1'b0;
    end else if (arb) begin
      cnt <= '0;
      if (req == 2'b00) begin
        state <= IDLE;
      end else begin
        state <= win ? OWN1 : OWN0;
        s     <= win;
        ptr   <= win;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mux_21_rr_sel.sv
// Self-checking bench for mux_21_rr_sel. Two instances share the same
// stimulus: one with BURST=4 and one with BURST=1. A behavioural model
// tracks owner, beats used and last winner per instance.
module tb_mux_21_rr_sel;

  logic       clk;
  logic       rst;
  logic [1:0] req;

  logic       s_w    [2];
  logic [1:0] gnt_w  [2];
  logic       busy_w [2];
  logic       last_w [2];

  int checks;
  int errors;

  // model state per instance: owner -1 = idle
  int m_burst [2];
  int m_owner [2];
  int m_beats [2];
  int m_prev  [2];
  int m_sel   [2];

  mux_21_rr_sel #(.BURST(4), .CW(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .s   (s_w[0]),
    .gnt (gnt_w[0]),
    .busy(busy_w[0]),
    .last(last_w[0])
  );

  mux_21_rr_sel #(.BURST(1), .CW(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .s   (s_w[1]),
    .gnt (gnt_w[1]),
    .busy(busy_w[1]),
    .last(last_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model for instance k across one clock edge.
  task automatic model_step(input int k, input logic r, input logic [1:0] q);
    bit ending;
    int winner;
    if (r) begin
      m_owner[k] = -1;
      m_beats[k] = 0;
      m_prev[k]  = 1;
      m_sel[k]   = 0;
    end else begin
      ending = (m_owner[k] < 0) || (m_beats[k] + 1 == m_burst[k]) || (q[m_owner[k]] == 1'b0);
      if (!ending) begin
        m_beats[k] = m_beats[k] + 1;
      end else if (q == 2'b00) begin
        m_owner[k] = -1;
        m_beats[k] = 0;
      end else begin
        if (q == 2'b11) winner = 1 - m_prev[k];
        else if (q == 2'b10) winner = 1;
        else winner = 0;
        m_owner[k] = winner;
        m_prev[k]  = winner;
        m_sel[k]   = winner;
        m_beats[k] = 0;
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic [1:0] exp_gnt;
    logic       exp_last;
    string      pfx;
    pfx      = (k == 0) ? "b4" : "b1";
    exp_gnt  = (m_owner[k] < 0) ? 2'b00 : ((m_owner[k] == 1) ? 2'b10 : 2'b01);
    exp_last = (m_owner[k] >= 0) && (m_beats[k] == m_burst[k] - 1);
    check({pfx, "_gnt"},  8'(gnt_w[k]),  8'(exp_gnt));
    check({pfx, "_s"},    8'(s_w[k]),    8'(m_sel[k][0]));
    check({pfx, "_busy"}, 8'(busy_w[k]), 8'(m_owner[k] >= 0));
    check({pfx, "_last"}, 8'(last_w[k]), 8'(exp_last));
  endtask

  task automatic cycle(input logic r, input logic [1:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, r, q);
    #1;
    for (int k = 0; k < 2; k++) check_dut(k);
  endtask

  task automatic run(input logic r, input logic [1:0] q, input int n);
    for (int i = 0; i < n; i++) cycle(r, q);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    m_burst[0] = 4;
    m_burst[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_beats[k] = 0;
      m_prev[k]  = 1;
      m_sel[k]   = 0;
    end
    rst = 1'b1;
    req = 2'b11;

    // reset held with both requesting
    run(1'b1, 2'b11, 3);
    check("rst_gnt", 8'(gnt_w[0]), 8'h00);
    check("rst_s",   8'(s_w[0]),   8'h00);
    // first arbitration after reset favours source 0
    cycle(1'b0, 2'b11);
    check("release_gnt", 8'(gnt_w[0]), 8'h01);
    check("release_s",   8'(s_w[0]),   8'h00);

    // contention
    run(1'b0, 2'b11, 11);
    // idle with s holding
    run(1'b0, 2'b00, 2);
    // single source 1 held
    run(1'b0, 2'b10, 10);
    run(1'b0, 2'b00, 1);
    // early drop: grant 0 for 2 beats, then drop with req[1] pending
    run(1'b0, 2'b01, 2);
    run(1'b0, 2'b10, 3);
    // idle and hold, then later req=10
    run(1'b0, 2'b01, 2);
    run(1'b0, 2'b00, 3);
    check("idle_s_hold", 8'(s_w[0]), 8'h00);
    run(1'b0, 2'b10, 1);
    check("late_req_s", 8'(s_w[0]), 8'h01);
    run(1'b0, 2'b10, 1);
    // contention then reset mid-burst
    run(1'b0, 2'b11, 3);
    run(1'b1, 2'b11, 1);
    check("midburst_rst_gnt", 8'(gnt_w[1]), 8'h00);
    run(1'b0, 2'b11, 3);

    // randomized traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 40) == 0), 2'($urandom_range(0, 3)));
      for (int k = 0; k < 2; k++) begin
        check("inv_not11", 8'(gnt_w[k] == 2'b11), 8'h00);
        if (busy_w[k]) check("inv_gnt_s", 8'(gnt_w[k][s_w[k]]), 8'h01);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
